// File: rtl/cpu_control_pkg.sv
// Shared control types for the runahead operand validator.
package cpu_control_pkg;

  typedef enum logic [0:0] {
    RA_NORMAL   = 1'b0,
    RA_RUNAHEAD = 1'b1
  } ra_state_e;

  // Bit positions inside a 3-bit register status word.
  localparam int unsigned STATUS_DIRTY = 2;
  localparam int unsigned STATUS_TBW   = 1;
  localparam int unsigned STATUS_TBR   = 0;

endpackage

// File: rtl/runahead_poison_scoreboard.sv
// Per-register poison bits: set by diverted writers, cleared by load writeback.
module runahead_poison_scoreboard #(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  adv_i,
  input  logic                  flush_i,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_a_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_b_addr_i,
  output logic                  rd_a_o,
  output logic                  rd_b_o,
  output logic                  empty_o
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  logic [NUM_REGS-1:0] poison_q;
  logic [NUM_REGS-1:0] poison_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Clear is applied before set so a same-address set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_i) set_mask[set_addr_i] = 1'b1;
    if (clr_i) clr_mask[clr_addr_i] = 1'b1;
    poison_d = poison_q;
    if (flush_i) begin
      poison_d = '0;
    end else if (adv_i) begin
      poison_d = (poison_q & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      poison_q <= '0;
    end else begin
      poison_q <= poison_d;
    end
  end

  assign rd_a_o  = poison_q[rd_a_addr_i];
  assign rd_b_o  = poison_q[rd_b_addr_i];
  // Empty flag looks at the post-edge contents so the FSM can leave runahead
  // on the same edge that clears the last poisoned register.
  assign empty_o = (poison_d == '0);

endmodule

// File: rtl/runahead_operand_validator.sv
// Decides per issued instruction whether it executes normally or is diverted
// into the runahead queue because an operand is dirty, poisoned or forwarded
// from an earlier diverted instruction.
module runahead_operand_validator
  import cpu_control_pkg::*;
#(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned FWD_DEPTH   = 2,
  parameter int unsigned STRICT_READ = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [INSTR_W-1:0]    issue_instr,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic                  issue_dest_we,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [2:0]            a_status,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [2:0]            b_status,
  input  logic [FWD_DEPTH-1:0]  fwd_a,
  input  logic [FWD_DEPTH-1:0]  fwd_b,
  input  logic                  load_wb_valid,
  input  logic [REG_ADDR_W-1:0] load_wb_addr,
  input  logic                  flush,
  output logic                  exec_valid,
  output logic                  invalidate,
  output logic                  fwd_load_a,
  output logic                  fwd_load_b,
  output logic                  rq_valid,
  input  logic                  rq_ready,
  output logic [INSTR_W-1:0]    rq_instr,
  output logic                  rq_a_would_fwd,
  output logic                  rq_b_would_fwd,
  output logic                  runahead_active,
  output logic [CNT_W-1:0]      divert_count
);

  ra_state_e            state_q, state_d;
  logic [FWD_DEPTH-1:0] hist_q, hist_d;
  logic                 rq_valid_q, rq_valid_d;
  logic [INSTR_W-1:0]   rq_instr_q, rq_instr_d;
  logic                 rq_a_q, rq_a_d;
  logic                 rq_b_q, rq_b_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic load_match_a, load_match_b;
  logic poison_a, poison_b, poison_empty_next;
  logic dirty_a, dirty_b, fdirty_a, fdirty_b;
  logic divert, accept, divert_acc;
  logic unused_status;

  assign unused_status = a_status[STATUS_TBW] ^ b_status[STATUS_TBW] ^ b_status[STATUS_TBR];

  assign load_match_a = load_wb_valid && (load_wb_addr == a_addr);
  assign load_match_b = load_wb_valid && (load_wb_addr == b_addr);

  assign dirty_a  = (a_status[STATUS_DIRTY] || poison_a) && !load_match_a;
  assign dirty_b  = (b_status[STATUS_DIRTY] || poison_b) && !load_match_b;
  assign fdirty_a = |(fwd_a & hist_q);
  assign fdirty_b = |(fwd_b & hist_q);

  assign divert = dirty_a || dirty_b || fdirty_a || fdirty_b ||
                  ((STRICT_READ != 0) && a_status[STATUS_TBR]);

  assign issue_ready = clk_en && (!rq_valid_q || rq_ready) && !flush;
  assign accept      = issue_valid && issue_ready;
  assign divert_acc  = accept && divert;

  runahead_poison_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_poison (
    .clk_i       (clk),
    .rst_ni      (async_rst_n),
    .adv_i       (clk_en),
    .flush_i     (flush),
    .set_i       (divert_acc && issue_dest_we),
    .set_addr_i  (issue_dest),
    .clr_i       (load_wb_valid),
    .clr_addr_i  (load_wb_addr),
    .rd_a_addr_i (a_addr),
    .rd_b_addr_i (b_addr),
    .rd_a_o      (poison_a),
    .rd_b_o      (poison_b),
    .empty_o     (poison_empty_next)
  );

  // Next-state for FSM, divert history, runahead queue register and counter.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    rq_valid_d = rq_valid_q;
    rq_instr_d = rq_instr_q;
    rq_a_d     = rq_a_q;
    rq_b_d     = rq_b_q;
    count_d    = count_q;
    if (flush) begin
      state_d    = RA_NORMAL;
      hist_d     = '0;
      rq_valid_d = 1'b0;
      count_d    = '0;
    end else if (clk_en) begin
      if (accept) begin
        hist_d = (hist_q << 1) | FWD_DEPTH'(divert);
      end
      if (divert_acc) begin
        rq_valid_d = 1'b1;
        rq_instr_d = issue_instr;
        rq_a_d     = |fwd_a;
        rq_b_d     = |fwd_b;
      end else if (rq_ready) begin
        rq_valid_d = 1'b0;
      end
      if (divert_acc && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
      unique case (state_q)
        RA_NORMAL: begin
          if (divert_acc) state_d = RA_RUNAHEAD;
        end
        RA_RUNAHEAD: begin
          if (poison_empty_next && !rq_valid_q && !divert_acc) begin
            state_d = RA_NORMAL;
            count_d = '0;
          end
        end
        default: state_d = RA_NORMAL;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q    <= RA_NORMAL;
      hist_q     <= '0;
      rq_valid_q <= 1'b0;
      rq_instr_q <= '0;
      rq_a_q     <= 1'b0;
      rq_b_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      rq_valid_q <= rq_valid_d;
      rq_instr_q <= rq_instr_d;
      rq_a_q     <= rq_a_d;
      rq_b_q     <= rq_b_d;
      count_q    <= count_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign exec_valid      = async_rst_n && accept && !divert;
  assign invalidate      = async_rst_n && issue_valid && divert;
  assign fwd_load_a      = async_rst_n && load_match_a;
  assign fwd_load_b      = async_rst_n && load_match_b;
  assign rq_valid        = rq_valid_q;
  assign rq_instr        = rq_instr_q;
  assign rq_a_would_fwd  = rq_a_q;
  assign rq_b_would_fwd  = rq_b_q;
  assign runahead_active = (state_q == RA_RUNAHEAD);
  assign divert_count    = count_q;

endmodule

// File: tb/tb_runahead_operand_validator.sv
`timescale 1ns/1ps
module tb_runahead_operand_validator;

  localparam int unsigned IW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned FD = 2;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          async_rst_n;
  logic          clk_en;
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_instr;
  logic [AW-1:0] issue_dest;
  logic          issue_dest_we;
  logic [AW-1:0] a_addr;
  logic [2:0]    a_status;
  logic [AW-1:0] b_addr;
  logic [2:0]    b_status;
  logic [FD-1:0] fwd_a;
  logic [FD-1:0] fwd_b;
  logic          load_wb_valid;
  logic [AW-1:0] load_wb_addr;
  logic          flush;
  logic          exec_valid;
  logic          invalidate;
  logic          fwd_load_a;
  logic          fwd_load_b;
  logic          rq_valid;
  logic          rq_ready;
  logic [IW-1:0] rq_instr;
  logic          rq_a_would_fwd;
  logic          rq_b_would_fwd;
  logic          runahead_active;
  logic [CW-1:0] divert_count;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  runahead_operand_validator #(
    .INSTR_W     (IW),
    .REG_ADDR_W  (AW),
    .FWD_DEPTH   (FD),
    .STRICT_READ (1),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .async_rst_n     (async_rst_n),
    .clk_en          (clk_en),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_instr     (issue_instr),
    .issue_dest      (issue_dest),
    .issue_dest_we   (issue_dest_we),
    .a_addr          (a_addr),
    .a_status        (a_status),
    .b_addr          (b_addr),
    .b_status        (b_status),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .load_wb_valid   (load_wb_valid),
    .load_wb_addr    (load_wb_addr),
    .flush           (flush),
    .exec_valid      (exec_valid),
    .invalidate      (invalidate),
    .fwd_load_a      (fwd_load_a),
    .fwd_load_b      (fwd_load_b),
    .rq_valid        (rq_valid),
    .rq_ready        (rq_ready),
    .rq_instr        (rq_instr),
    .rq_a_would_fwd  (rq_a_would_fwd),
    .rq_b_would_fwd  (rq_b_would_fwd),
    .runahead_active (runahead_active),
    .divert_count    (divert_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    clk_en        = 1'b1;
    issue_valid   = 1'b0;
    issue_instr   = '0;
    issue_dest    = '0;
    issue_dest_we = 1'b0;
    a_addr        = '0;
    a_status      = '0;
    b_addr        = '0;
    b_status      = '0;
    fwd_a         = '0;
    fwd_b         = '0;
    load_wb_valid = 1'b0;
    load_wb_addr  = '0;
    flush         = 1'b0;
    rq_ready      = 1'b1;
  endtask

  task automatic issue(input logic [IW-1:0] ins, input logic [AW-1:0] aa, input logic [2:0] ast,
                       input logic [AW-1:0] ba, input logic [2:0] bst,
                       input logic [AW-1:0] dst, input logic we);
    issue_valid   = 1'b1;
    issue_instr   = ins;
    a_addr        = aa;
    a_status      = ast;
    b_addr        = ba;
    b_status      = bst;
    issue_dest    = dst;
    issue_dest_we = we;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    async_rst_n = 1'b0;
    issue(16'h0001, 4'd3, 3'b100, 4'd0, 3'b000, 4'd0, 1'b0);
    #3;
    check("rst_exec_valid",  exec_valid,      0);
    check("rst_invalidate",  invalidate,      0);
    check("rst_issue_ready", issue_ready,     1);
    check("rst_rq_valid",    rq_valid,        0);
    check("rst_runahead",    runahead_active, 0);
    check("rst_count",       divert_count,    0);
    tick();
    async_rst_n = 1'b1;
    idle();
    #1;

    // Dirty operand A with no matching load writeback diverts.
    issue(16'hA001, 4'd3, 3'b100, 4'd0, 3'b000, 4'd7, 1'b1);
    rq_ready = 1'b0;
    #1;
    check("dirty_a_invalidate", invalidate,  1);
    check("dirty_a_exec",       exec_valid,  0);
    check("dirty_a_ready",      issue_ready, 1);
    tick();
    idle();
    rq_ready = 1'b0;
    #1;
    check("div1_rq_valid", rq_valid,        1);
    check("div1_rq_instr", rq_instr,        16'hA001);
    check("div1_runahead", runahead_active, 1);
    check("div1_count",    divert_count,    1);

    // Queue stalled: issue blocked and queued instruction stable.
    issue(16'h0B02, 4'd1, 3'b000, 4'd2, 3'b000, 4'd0, 1'b0);
    rq_ready = 1'b0;
    #1;
    check("stall_ready", issue_ready, 0);
    check("stall_exec",  exec_valid,  0);
    tick();
    check("stall_rq_instr", rq_instr, 16'hA001);
    check("stall_rq_valid", rq_valid, 1);
    rq_ready = 1'b1;
    #1;
    check("drain_ready", issue_ready, 1);
    check("drain_exec",  exec_valid,  1);
    tick();
    idle();
    #1;
    check("drained_rq_valid", rq_valid,        0);
    check("poison7_runahead", runahead_active, 1);
    load_wb_valid = 1'b1;
    load_wb_addr  = 4'd7;
    #1;
    tick();
    idle();
    #1;
    check("exit1_runahead", runahead_active, 0);
    check("exit1_count",    divert_count,    0);

    // Dirty A rescued by a same-cycle load writeback to A.
    issue(16'hC003, 4'd3, 3'b100, 4'd0, 3'b000, 4'd0, 1'b0);
    load_wb_valid = 1'b1;
    load_wb_addr  = 4'd3;
    #1;
    check("ldfwd_exec",       exec_valid, 1);
    check("ldfwd_fwd_load_a", fwd_load_a, 1);
    check("ldfwd_invalidate", invalidate, 0);
    tick();
    idle();
    #1;
    check("ldfwd_runahead", runahead_active, 0);

    // Poisoned destination propagates to a later reader on operand B.
    issue(16'hD004, 4'd1, 3'b100, 4'd0, 3'b000, 4'd5, 1'b1);
    #1;
    check("r5_div_invalidate", invalidate, 1);
    tick();
    issue(16'hD005, 4'd2, 3'b000, 4'd5, 3'b000, 4'd0, 1'b0);
    #1;
    check("r5_rd_invalidate", invalidate, 1);
    check("r5_rd_exec",       exec_valid, 0);
    tick();
    idle();
    #1;
    check("r5_rq_instr", rq_instr,     16'hD005);
    check("r5_count",    divert_count, 2);
    tick();
    check("r5_drained",  rq_valid,        0);
    check("r5_runahead", runahead_active, 1);
    load_wb_valid = 1'b1;
    load_wb_addr  = 4'd5;
    #1;
    tick();
    idle();
    #1;
    check("r5_exit_runahead", runahead_active, 0);
    check("r5_exit_count",    divert_count,    0);

    // Two clean issues shift the divert history back to zero.
    issue(16'hE006, 4'd1, 3'b000, 4'd2, 3'b000, 4'd0, 1'b0);
    #1;
    check("clean1_exec", exec_valid, 1);
    tick();
    issue(16'hE007, 4'd1, 3'b000, 4'd2, 3'b000, 4'd0, 1'b0);
    #1;
    check("clean2_exec", exec_valid, 1);
    tick();
    idle();
    #1;

    // Forward from a diverted producer diverts; from a clean one does not.
    issue(16'hF008, 4'd1, 3'b100, 4'd0, 3'b000, 4'd0, 1'b0);
    #1;
    check("d1_invalidate", invalidate, 1);
    tick();
    issue(16'hF009, 4'd2, 3'b000, 4'd3, 3'b000, 4'd0, 1'b0);
    fwd_a = 2'b10;
    #1;
    check("fwd10_exec",       exec_valid, 1);
    check("fwd10_invalidate", invalidate, 0);
    tick();
    issue(16'hF00A, 4'd1, 3'b100, 4'd0, 3'b000, 4'd0, 1'b0);
    fwd_a = 2'b00;
    #1;
    tick();
    issue(16'hF00B, 4'd2, 3'b000, 4'd3, 3'b000, 4'd0, 1'b0);
    fwd_a = 2'b01;
    #1;
    check("fwd01_invalidate", invalidate, 1);
    check("fwd01_exec",       exec_valid, 0);
    tick();
    idle();
    #1;
    check("fwd01_rq_instr", rq_instr,       16'hF00B);
    check("fwd01_rq_a_fwd", rq_a_would_fwd, 1);
    check("fwd01_rq_b_fwd", rq_b_would_fwd, 0);
    check("fwd01_count",    divert_count,   3);
    tick();
    tick();
    check("fwd_exit_runahead", runahead_active, 0);
    check("fwd_exit_count",    divert_count,    0);

    // Five diverts saturate a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      issue(IW'(16'h1000 + i), 4'd1, 3'b100, 4'd0, 3'b000, 4'd9, 1'b1);
      tick();
    end
    idle();
    #1;
    check("sat_count",    divert_count,    3);
    check("sat_runahead", runahead_active, 1);
    check("sat_rq_valid", rq_valid,        1);

    // Flush works even with clk_en low.
    clk_en = 1'b0;
    flush  = 1'b1;
    #1;
    check("flush_ready", issue_ready, 0);
    tick();
    idle();
    #1;
    check("flush_count",    divert_count,    0);
    check("flush_runahead", runahead_active, 0);
    check("flush_rq_valid", rq_valid,        0);
    issue(16'h2000, 4'd9, 3'b000, 4'd9, 3'b000, 4'd0, 1'b0);
    #1;
    check("flush_poison_exec", exec_valid, 1);
    tick();
    idle();
    issue(16'h2001, 4'd9, 3'b000, 4'd9, 3'b000, 4'd0, 1'b0);
    clk_en = 1'b0;
    #1;
    check("clken_ready", issue_ready, 0);
    check("clken_exec",  exec_valid,  0);
    tick();
    idle();
    #1;

    // Asynchronous reset in the middle of runahead.
    issue(16'h3001, 4'd1, 3'b100, 4'd0, 3'b000, 4'd4, 1'b1);
    tick();
    idle();
    #1;
    check("pre_rst_runahead", runahead_active, 1);
    issue(16'h3002, 4'd1, 3'b100, 4'd0, 3'b000, 4'd0, 1'b0);
    load_wb_valid = 1'b1;
    load_wb_addr  = 4'd1;
    #1;
    async_rst_n = 1'b0;
    #1;
    check("mid_rst_runahead",  runahead_active, 0);
    check("mid_rst_rq_valid",  rq_valid,        0);
    check("mid_rst_rq_instr",  rq_instr,        0);
    check("mid_rst_count",     divert_count,    0);
    check("mid_rst_invalid",   invalidate,      0);
    check("mid_rst_exec",      exec_valid,      0);
    check("mid_rst_fwd_ld_a",  fwd_load_a,      0);
    check("mid_rst_rq_a_fwd",  rq_a_would_fwd,  0);
    check("mid_rst_ready",     issue_ready,     1);
    #2;
    async_rst_n = 1'b1;
    idle();
    tick();
    issue(16'h3003, 4'd4, 3'b000, 4'd4, 3'b000, 4'd0, 1'b0);
    #1;
    check("post_rst_exec", exec_valid, 1);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/runahead_operand_validator.md
RUNAHEAD_OPERAND_VALIDATOR -- requirements
Module: runahead_operand_validator

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-002 SHALL have parameter REG_ADDR_W, default 4, register address width; NUM_REGS = 2**REG_ADDR_W.
REQ-003 SHALL have parameter FWD_DEPTH, default 2, forward-path count and divert-history depth (1..4).
REQ-004 SHALL have parameter STRICT_READ, default 1; when 1, operand A to-be-read forces a divert.
REQ-005 SHALL have parameter CNT_W, default 8, divert-counter width.
REQ-006 SHALL have ports: clk in 1, the single clock; async_rst_n in 1, reset, asynchronous and active-low; clk_en in 1, global advance enable.
REQ-007 SHALL have ports: issue_valid in 1; issue_ready out 1; issue_instr in INSTR_W; issue_dest in REG_ADDR_W; issue_dest_we in 1.
REQ-008 SHALL have ports: a_addr in REG_ADDR_W; a_status in 3, [2]dirty [1]to-be-written [0]to-be-read; b_addr in REG_ADDR_W; b_status in 3.
REQ-009 SHALL have ports: fwd_a in FWD_DEPTH; fwd_b in FWD_DEPTH, where bit i is the forward from the instruction issued i+1 accepted cycles earlier.
REQ-010 SHALL have ports: load_wb_valid in 1; load_wb_addr in REG_ADDR_W; flush in 1.
REQ-011 SHALL have ports: exec_valid out 1; invalidate out 1; fwd_load_a out 1; fwd_load_b out 1.
REQ-012 SHALL have ports: rq_valid out 1; rq_ready in 1; rq_instr out INSTR_W; rq_a_would_fwd out 1; rq_b_would_fwd out 1.
REQ-013 SHALL have ports: runahead_active out 1; divert_count out CNT_W.

Function
REQ-014 SHALL compute load_match_x = load_wb_valid && load_wb_addr == x_addr, with fwd_load_x = load_match_x.
REQ-015 SHALL compute dirty_x = (x_status[2] || poison[x_addr]) && !load_match_x, for x in {a, b}.
REQ-016 SHALL compute fdirty_x = |(fwd_x & hist).
REQ-017 SHALL compute divert = dirty_a || dirty_b || fdirty_a || fdirty_b || (STRICT_READ && a_status[0]).
REQ-018 SHALL drive issue_ready = clk_en && (!rq_valid || rq_ready) && !flush; accept = issue_valid && issue_ready.
REQ-019 SHALL drive exec_valid = accept && !divert and invalidate = issue_valid && divert, both combinationally.
REQ-020 SHALL shift hist (FWD_DEPTH bits) as {hist[FWD_DEPTH-2:0], divert} on each accept; hist SHALL hold when there is no accept.
REQ-021 SHALL load the rq output register on accept && divert, latching instr, |fwd_a and |fwd_b; rq_valid SHALL clear on rq_ready when no new load occurs.
REQ-022 SHALL set poison[issue_dest] on accept && divert && issue_dest_we, and clear poison[load_wb_addr] on load_wb_valid; set wins on the same address in the same cycle.
REQ-023 SHALL implement FSM NORMAL, RUNAHEAD.
REQ-024 SHALL transition NORMAL -> RUNAHEAD on accept && divert.
REQ-025 SHALL transition RUNAHEAD -> NORMAL when poison is all-zero next cycle, !rq_valid, and there is no accept && divert.
REQ-026 SHALL drive runahead_active = (state == RUNAHEAD).
REQ-027 SHALL increment divert_count on each accept && divert, saturating at 2**CNT_W-1, and clear it on entry to NORMAL.
REQ-028 SHALL, on flush, clear poison, hist, rq_valid and divert_count and force NORMAL on the next edge, independent of clk_en.
REQ-029 SHALL advance all state (except flush) only when clk_en = 1.

Reset
REQ-030 SHALL, on async_rst_n = 0, immediately set state NORMAL, poison 0, hist 0, rq_valid 0, rq_instr 0, divert_count 0.
REQ-031 SHALL hold all outputs at 0 during reset, except issue_ready, which SHALL equal clk_en && !flush.

Structure
REQ-032 SHALL place the FSM state enum and the status-bit index constants in shared package cpu_control_pkg.
REQ-033 SHALL use one sub-module, runahead_poison_scoreboard, to hold the NUM_REGS poison bits with set/clear/read ports and an empty flag.

Verification
REQ-034 SHALL cover: a_status = 3'b100, load_wb for a_addr absent -> invalidate = 1, rq_valid = 1 next cycle, runahead_active = 1.
REQ-035 SHALL cover: the same as REQ-034 with load_wb_valid and load_wb_addr = a_addr -> exec_valid = 1, fwd_load_a = 1, no divert.
REQ-036 SHALL cover: a divert writing r5, then the next instruction with b_addr = 5 -> divert; then load_wb to r5 with rq drained -> NORMAL next cycle.
REQ-037 SHALL cover: a divert, then a clean instruction with fwd_a = 2'b01 -> divert; with fwd_a = 2'b10 and hist = 2'b01 -> exec_valid = 1.
REQ-038 SHALL cover: rq_ready = 0 with rq_valid = 1 -> issue_ready = 0 and rq_instr stable; rq_ready = 1 -> the issue is accepted that cycle.
REQ-039 SHALL cover: CNT_W = 2, five diverts -> divert_count = 3; flush -> count 0, poison empty, NORMAL; async_rst_n low mid-RUNAHEAD -> all reset values.
